// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream master.
// The optional frame marker is enabled by defining FIFO_STREAM_READER_FRAME_EN.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 32;
    localparam int unsigned FIFO_PTR_DEF   = 4;
    localparam int unsigned SKID_DEPTH     = 2;
    localparam int unsigned OCC_W          = $clog2(SKID_DEPTH + 1);
    localparam int unsigned FRAME_CNT_W    = 16;

    typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer: words landed from the FIFO queue here until the
// downstream consumer accepts them. The head register is the stream data output.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output occ_t             o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    occ_t             r_occ;

    // Upstream credit logic guarantees no push into a full buffer and no pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (i_push && i_pop) begin
            if (r_occ == occ_t'(SKID_DEPTH)) begin
                r_head <= r_tail;
                r_tail <= i_data;
            end else begin
                r_head <= i_data;
            end
        end else if (i_push) begin
            if (r_occ == '0) begin
                r_head <= i_data;
            end else begin
                r_tail <= i_data;
            end
            r_occ <= r_occ + occ_t'(1);
        end else if (i_pop) begin
            r_head <= r_tail;
            r_occ  <= r_occ - occ_t'(1);
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads the synchronous FIFO with credit-based flow control and re-presents the words
// as a valid/ready stream. Define FIFO_STREAM_READER_FRAME_EN to enable m_last framing.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_PTR   = FIFO_PTR_DEF,
    parameter int unsigned FRAME_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fifo_rden,
    input  logic [FIFO_WIDTH-1:0] fifo_rddata,
    input  logic                  fifo_empty,
    input  logic [FIFO_PTR:0]     fifo_data_avail,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [FIFO_PTR:0]     rd_level,
    output logic                  busy
);

    localparam int unsigned CRED_W = OCC_W + 1;

    logic              r_inflight;
    logic [FIFO_PTR:0] r_rd_level;
    occ_t              w_occ;
    logic              w_pop;
    logic [CRED_W-1:0] w_credits;

    // A slot is reserved for every word either buffered or still on its way from the FIFO.
    assign w_credits = CRED_W'(w_occ) + CRED_W'(r_inflight);
    assign m_valid   = (w_occ != '0);
    assign w_pop     = m_valid && m_ready;
    assign fifo_rden = enable && !fifo_empty &&
                       ((w_credits < CRED_W'(SKID_DEPTH)) ||
                        ((w_credits == CRED_W'(SKID_DEPTH)) && w_pop));
    assign busy      = (w_credits != '0);
    assign rd_level  = r_rd_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_rd_level <= '0;
        end else begin
            r_inflight <= fifo_rden;
            r_rd_level <= fifo_data_avail;
        end
    end

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_data (fifo_rddata),
        .i_pop  (w_pop),
        .o_occ  (w_occ),
        .o_head (m_data)
    );

`ifdef FIFO_STREAM_READER_FRAME_EN
    localparam logic [FRAME_CNT_W-1:0] LAST_IDX = FRAME_CNT_W'(FRAME_LEN - 1);

    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    // Position of the head word within its frame; advances only on accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_pop) begin
            r_frame_cnt <= (r_frame_cnt == LAST_IDX) ? '0 : r_frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign m_last = m_valid && (r_frame_cnt == LAST_IDX);
`else
    logic w_unused_frame_len;

    assign w_unused_frame_len = (FRAME_LEN == 0);
    assign m_last             = 1'b0;
`endif

endmodule
